// File: rtl/final_soc_led_pio.sv
// final_soc_led_pio: Avalon-MM output PIO with set/clear writes and registered readback
// Optional blink engine enabled by defining FINAL_SOC_LED_PIO_BLINK_EN
`timescale 1ns/1ps
module final_soc_led_pio #(
    parameter int                    DATA_WIDTH   = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    PERIOD_WIDTH = 26,
    parameter int                    PERIOD_RESET = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic [DATA_WIDTH-1:0] blink_bits;
    logic [31:0]           mask_rd;
    logic [31:0]           period_rd;
    logic [31:0]           rd_d;
    logic                  unused_cfg;
    assign wr = chipselect & ~write_n;
    assign wd = writedata[DATA_WIDTH-1:0];
    assign unused_cfg = ^{writedata, PERIOD_WIDTH[0], PERIOD_RESET[0]};
    always_comb begin
        data_d = !wr               ? data_q      :
                 address == 3'd0   ? wd          :
                 address == 3'd1   ? data_q | wd :
                 address == 3'd2   ? data_q & ~wd : data_q;
    end
`ifdef FINAL_SOC_LED_PIO_BLINK_EN
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [PERIOD_WIDTH-1:0] period_q;
    logic [PERIOD_WIDTH-1:0] count_q;
    logic                    phase_q;
    logic [0:0]              state;
    logic                    mask_wr;
    logic                    period_wr;
    logic                    terminal;
    assign state     = (period_q == '0) ? IDLE : RUN;
    assign mask_wr   = wr && address == 3'd3;
    assign period_wr = wr && address == 3'd4;
    assign terminal  = count_q == period_q - PERIOD_WIDTH'(1);
    // A period write restarts the cycle and overrides a coincident terminal count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q   <= '0;
            period_q <= PERIOD_WIDTH'(PERIOD_RESET);
            count_q  <= '0;
            phase_q  <= 1'b0;
        end else begin
            if (mask_wr)
                mask_q <= wd;
            if (period_wr) begin
                period_q <= writedata[PERIOD_WIDTH-1:0];
                count_q  <= '0;
                phase_q  <= 1'b0;
            end else if (state == IDLE) begin
                count_q <= '0;
                phase_q <= 1'b0;
            end else if (terminal) begin
                count_q <= '0;
                phase_q <= ~phase_q;
            end else begin
                count_q <= count_q + PERIOD_WIDTH'(1);
            end
        end
    end
    assign blink_bits = mask_q & {DATA_WIDTH{phase_q}};
    assign mask_rd    = 32'(mask_q);
    assign period_rd  = 32'(period_q);
`else
    assign blink_bits = '0;
    assign mask_rd    = '0;
    assign period_rd  = '0;
`endif
    always_comb begin
        rd_d = address == 3'd0 ? 32'(data_q) :
               address == 3'd3 ? mask_rd     :
               address == 3'd4 ? period_rd   : '0;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= RESET_VALUE;
            out_port <= RESET_VALUE;
            readdata <= '0;
        end else begin
            data_q   <= data_d;
            out_port <= data_q ^ blink_bits;
            readdata <= rd_d;
        end
    end
endmodule

// File: tb/tb_final_soc_led_pio.sv
// tb_final_soc_led_pio: directed self-checking bench for final_soc_led_pio
// Blink checks run when FINAL_SOC_LED_PIO_BLINK_EN is defined, disabled-build checks otherwise
`timescale 1ns/1ps
module tb_final_soc_led_pio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    int          total = 0;
    int          passes = 0;
    final_soc_led_pio dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .out_port(out_port)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a;
        writedata = d;
        chipselect = 1'b1;
        write_n = 1'b0;
        step();
        chipselect = 1'b0;
        write_n = 1'b1;
    endtask
    task automatic rd(input logic [2:0] a, input string tag, input logic [31:0] exp);
        address = a;
        step();
        check(tag, readdata, exp);
    endtask
`ifdef FINAL_SOC_LED_PIO_BLINK_EN
    logic [11:0] exp_seq = 12'b110000111100;
`endif
    initial begin
        step();
        step();
        check("reset_readdata", readdata, 32'h0);
        check("reset_out", {24'h0, out_port}, 32'h0);
        reset = 1'b0;
        rd(3'd0, "rd_data_init", 32'h0);
        wr(3'd0, 32'hFFFF_FFA5);
        rd(3'd0, "rd_data_a5", 32'h0000_00A5);
        check("out_a5", {24'h0, out_port}, 32'hA5);
        wr(3'd1, 32'h0F);
        rd(3'd0, "rd_after_set", 32'hAF);
        check("out_after_set", {24'h0, out_port}, 32'hAF);
        wr(3'd2, 32'h81);
        rd(3'd0, "rd_after_clear", 32'h2E);
        check("out_after_clear", {24'h0, out_port}, 32'h2E);
        rd(3'd1, "rd_outset_zero", 32'h0);
        rd(3'd2, "rd_outclear_zero", 32'h0);
        address = 3'd0;
        step();
        check("pre_reset_readdata", readdata, 32'h2E);
        reset = 1'b1;
        #1;
        check("midreset_readdata", readdata, 32'h0);
        check("midreset_out", {24'h0, out_port}, 32'h0);
        step();
        reset = 1'b0;
        rd(3'd0, "rd_after_midreset", 32'h0);
        wr(3'd0, 32'h3C);
        wr(3'd5, 32'hFF);
        wr(3'd6, 32'hFF);
        wr(3'd7, 32'hFF);
        rd(3'd0, "rd_data_after_reserved", 32'h3C);
        check("out_after_reserved", {24'h0, out_port}, 32'h3C);
        rd(3'd7, "rd_reserved_zero", 32'h0);
`ifdef FINAL_SOC_LED_PIO_BLINK_EN
        rd(3'd4, "rd_period_reset", 32'd25000000);
        wr(3'd4, 32'd4);
        wr(3'd3, 32'h01);
        wr(3'd0, 32'h00);
        for (int i = 0; i < 12; i++) begin
            step();
            check($sformatf("blink_cycle%0d", i), {24'h0, out_port}, {31'h0, exp_seq[i]});
        end
        rd(3'd3, "rd_mask", 32'h01);
        rd(3'd4, "rd_period", 32'd4);
        wr(3'd4, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("idle_cycle%0d", i), {24'h0, out_port}, 32'h0);
        end
        wr(3'd4, 32'd4);
        for (int i = 0; i < 6; i++)
            step();
        check("phase_high_before_rewrite", {24'h0, out_port}, 32'h1);
        wr(3'd4, 32'd4);
        check("out_on_rewrite_edge", {24'h0, out_port}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("after_rewrite%0d", i), {24'h0, out_port}, 32'h0);
        end
        step();
        check("toggle_after_rewrite", {24'h0, out_port}, 32'h1);
`else
        wr(3'd3, 32'hFF);
        wr(3'd4, 32'hFF);
        rd(3'd3, "rd_mask_absent", 32'h0);
        rd(3'd4, "rd_period_absent", 32'h0);
        wr(3'd0, 32'h5A);
        step();
        check("out_tracks_data", {24'h0, out_port}, 32'h5A);
        for (int i = 0; i < 8; i++)
            step();
        check("out_steady", {24'h0, out_port}, 32'h5A);
`endif
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
